// File: rtl/mmio_pkg.sv
`default_nettype none
// Shared address map, UART FSM states and status-register bit positions
// for the memory-mapped peripherals on the processor data bus.
package mmio_pkg;

  localparam logic [15:0] LED_ADDR      = 16'h000F;
  localparam logic [15:0] TX_ADDR_DEF   = 16'h0010;
  localparam logic [15:0] STAT_ADDR_DEF = 16'h0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

endpackage
`default_nettype wire

// File: rtl/mmio_uart_tx_if.sv
`default_nettype none
// Processor data-bus slice seen by a memory-mapped peripheral:
// write strobe, word address, write data and registered read data.
interface mmio_uart_tx_if;
  logic        W;
  logic [15:0] word_addr;
  logic [31:0] dout;
  logic [31:0] rdata;

  modport master (output W, output word_addr, output dout, input rdata);
  modport slave  (input W, input word_addr, input dout, output rdata);
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// Show-ahead synchronous FIFO; pointers carry an extra wrap bit so full and
// empty fall out of a pointer compare. Caller must not write when full unless popping.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             wr_en_i,
  input  wire logic [WIDTH-1:0] wr_data_i,
  input  wire logic             rd_en_i,
  output logic      [WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// Memory-mapped 8N1 UART transmitter: bytes stored to TX_ADDR are queued in a
// FIFO and shifted out on txd; STAT_ADDR reads {overflow, empty, full, busy}.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] TX_ADDR      = TX_ADDR_DEF,
  parameter logic [15:0] STAT_ADDR    = STAT_ADDR_DEF
) (
  input  wire logic      clk,
  input  wire logic      resetn,
  mmio_uart_tx_if.slave  bus,
  output logic           txd,
  output logic           busy
);

  localparam int              CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          txd_q;
  logic          ovf_q, ovf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [3:0]    status_w;

  logic       fifo_full, fifo_empty, fifo_wr;
  logic [7:0] fifo_rdata;
  logic       push_req, ovf_clr, pop, drop, bit_end;
  logic       unused_dout_hi;

  assign push_req = bus.W && (bus.word_addr == TX_ADDR);
  assign ovf_clr  = bus.W && (bus.word_addr == STAT_ADDR) && bus.dout[0];
  assign bit_end  = (baud_q == BAUD_LAST);
  assign pop      = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  // A pop frees a slot in the same edge, so a push into a full FIFO still lands.
  assign fifo_wr  = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;
  assign unused_dout_hi = ^bus.dout[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .wr_en_i   (fifo_wr),
    .wr_data_i (bus.dout[7:0]),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_q    <= '0;
          bit_idx_q <= '0;
          if (pop) begin
            shift_q <= fifo_rdata;
            txd_q   <= 1'b0;
            state_q <= START;
          end else begin
            txd_q <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
            state_q   <= DATA;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            // Chain straight into the next frame when more data is queued.
            if (pop) begin
              shift_q <= fifo_rdata;
              txd_q   <= 1'b0;
              state_q <= START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    status_w             = '0;
    status_w[STAT_BUSY]  = busy;
    status_w[STAT_FULL]  = fifo_full;
    status_w[STAT_EMPTY] = fifo_empty;
    status_w[STAT_OVF]   = ovf_q;

    ovf_d = ovf_q;
    if (ovf_clr)   ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;

    rdata_d = '0;
    if (bus.word_addr == STAT_ADDR) rdata_d = {28'b0, status_w};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign txd       = txd_q;
  assign bus.rdata = rdata_q;

endmodule
`default_nettype wire
